// File: rtl/vga_fb_pkg.sv
// Shared framebuffer geometry, widths and types for the VGA framebuffer arbiter slice.
// Optional stall statistics are enabled with the VGA_FB_ARB_STATS_EN macro in vga_fb_arbiter.
package vga_fb_pkg;

    localparam int FB_ADDR_W   = 19;
    localparam int FB_DATA_W   = 8;
    localparam int FB_H_ACTIVE = 640;
    localparam int FB_V_ACTIVE = 480;
    localparam int FB_STALL_W  = 16;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_DATA_W-1:0] fb_pixel_t;

    // Width of a client index; a single client still needs a 1-bit pointer.
    function automatic int ptr_width(input int num_wr);
        return (num_wr > 1) ? $clog2(num_wr) : 1;
    endfunction

endpackage

// File: rtl/vga_fb_rr_pick.sv
// Combinational round-robin picker for framebuffer writer clients.
// The display request masks every grant; otherwise the scan starts at rr_ptr and wraps.
module vga_fb_rr_pick
    import vga_fb_pkg::*;
#(
    parameter int NUM_WR = 2,
    parameter int PTR_W  = ptr_width(NUM_WR)
) (
    input  logic              disp_req,
    input  logic [NUM_WR-1:0] wr_valid,
    input  logic [PTR_W-1:0]  rr_ptr,
    output logic [NUM_WR-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx,
    output logic              grant_any
);

    // Two passes: clients at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        if (!disp_req) begin
            for (int c = 0; c < NUM_WR; c++) begin
                if (!grant_any && wr_valid[c] && (PTR_W'(c) >= rr_ptr)) begin
                    grant[c]  = 1'b1;
                    grant_idx = PTR_W'(c);
                    grant_any = 1'b1;
                end
            end
            for (int c = 0; c < NUM_WR; c++) begin
                if (!grant_any && wr_valid[c] && (PTR_W'(c) < rr_ptr)) begin
                    grant[c]  = 1'b1;
                    grant_idx = PTR_W'(c);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM sequencer: scan-out fetch has strict priority, writers share idle cycles.
// Define VGA_FB_ARB_STATS_EN to build the per-writer saturating stall counters.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int NUM_WR = 2,
    parameter int RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disp_req,
    input  logic [ADDR_W-1:0]          disp_addr,
    output logic                       disp_valid,
    output logic [DATA_W-1:0]          disp_data,
    input  logic [NUM_WR-1:0]          wr_valid,
    output logic [NUM_WR-1:0]          wr_ready,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]          ram_addr,
    output logic                       ram_we,
    output logic [DATA_W-1:0]          ram_wdata,
    input  logic [DATA_W-1:0]          ram_rdata,
    input  logic                       stats_clr,
    output logic [NUM_WR*FB_STALL_W-1:0] stall_cnt
);

    localparam int PTR_W = ptr_width(NUM_WR);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [NUM_WR-1:0] grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [RD_LAT:0]   rd_pipe;

    vga_fb_rr_pick #(
        .NUM_WR (NUM_WR),
        .PTR_W  (PTR_W)
    ) u_pick (
        .disp_req  (disp_req),
        .wr_valid  (wr_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign wr_ready = grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int c = 0; c < NUM_WR; c++) begin
            if (grant[c]) begin
                sel_addr = wr_addr[c*ADDR_W +: ADDR_W];
                sel_data = wr_data[c*DATA_W +: DATA_W];
            end
        end
        ptr_next = (grant_idx == PTR_W'(NUM_WR-1)) ? '0 : grant_idx + 1'b1;
    end

    // On idle cycles the address is left alone so the RAM port does not toggle needlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rr_ptr    <= '0;
        end else if (disp_req) begin
            ram_we    <= 1'b0;
            ram_addr  <= disp_addr;
        end else if (grant_any) begin
            ram_we    <= 1'b1;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_data;
            rr_ptr    <= ptr_next;
        end else begin
            ram_we    <= 1'b0;
        end
    end

    // Tap RD_LAT marks the cycle in which ram_rdata belongs to a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe    <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            rd_pipe    <= {rd_pipe[RD_LAT-1:0], disp_req};
            disp_valid <= rd_pipe[RD_LAT];
            if (rd_pipe[RD_LAT]) begin
                disp_data <= ram_rdata;
            end
        end
    end

`ifdef VGA_FB_ARB_STATS_EN
    logic [FB_STALL_W-1:0] stall_q [NUM_WR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_WR; c++) begin
                stall_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_WR; c++) begin
                if (stats_clr) begin
                    stall_q[c] <= '0;
                end else if (wr_valid[c] && !grant[c] && (stall_q[c] != {FB_STALL_W{1'b1}})) begin
                    stall_q[c] <= stall_q[c] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int c = 0; c < NUM_WR; c++) begin
            stall_cnt[c*FB_STALL_W +: FB_STALL_W] = stall_q[c];
        end
    end
`else
    logic stats_clr_unused;

    assign stats_clr_unused = stats_clr;
    assign stall_cnt        = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Table-driven bench for vga_fb_arbiter with RAM-port and display scoreboards.
// Stall-counter checks are built when VGA_FB_ARB_STATS_EN is defined.
module tb_vga_fb_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 8;
    localparam int NUM_WR = 2;
    localparam int RD_LAT = 2;

    logic                     clk;
    logic                     rst_n;
    logic                     disp_req;
    logic [ADDR_W-1:0]        disp_addr;
    logic                     disp_valid;
    logic [DATA_W-1:0]        disp_data;
    logic [NUM_WR-1:0]        wr_valid;
    logic [NUM_WR-1:0]        wr_ready;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0]        ram_addr;
    logic                     ram_we;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        ram_rdata;
    logic                     stats_clr;
    logic [NUM_WR*16-1:0]     stall_cnt;

    typedef struct {
        logic        dreq;
        logic [18:0] daddr;
        logic [1:0]  wv;
        logic [18:0] a0;
        logic [7:0]  d0;
        logic [18:0] a1;
        logic [7:0]  d1;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        int          due;
        logic        we;
        logic [18:0] addr;
        logic [7:0]  data;
    } ram_exp_t;

    typedef struct {
        int         due;
        logic [7:0] data;
    } disp_exp_t;

    vec_t      vecs[$];
    ram_exp_t  ram_q[$];
    disp_exp_t disp_q[$];
    logic [7:0]  mem [4096];
    logic [7:0]  ref_mem [4096];
    logic [7:0]  rpipe [RD_LAT];
    logic [18:0] last_addr;
    int cyc;
    int n_vec;
    int n_fail;

    vga_fb_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .NUM_WR (NUM_WR),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .stats_clr  (stats_clr),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Synchronous RAM with RD_LAT register stages from the registered address to rdata.
    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
        end
        mem[5] = 8'hA5;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[11:0]] <= ram_wdata;
        rpipe[0] <= mem[ram_addr[11:0]];
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end

    assign ram_rdata = rpipe[RD_LAT-1];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic dreq, input logic [18:0] daddr, input logic [1:0] wv,
                                input logic [18:0] a0, input logic [7:0] d0,
                                input logic [18:0] a1, input logic [7:0] d1, input logic [1:0] er);
        vec_t v;
        v.dreq = dreq; v.daddr = daddr; v.wv = wv;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.exp_ready = er;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, 19'd0, 2'b00, 19'd0, 8'd0, 19'd0, 8'd0, 2'b00);
    endfunction

    function automatic vec_t fetch(input logic [18:0] a);
        return mk(1'b1, a, 2'b00, 19'd0, 8'd0, 19'd0, 8'd0, 2'b00);
    endfunction

    // Drives one cycle, checks the grant, and queues the RAM op and pixel this cycle should cause.
    task automatic apply_stimulus(input vec_t v);
        ram_exp_t  re;
        disp_exp_t de;
        @(posedge clk);
        #1;
        disp_req  = v.dreq;
        disp_addr = v.daddr;
        wr_valid  = v.wv;
        wr_addr   = {v.a1, v.a0};
        wr_data   = {v.d1, v.d0};
        #2;
        check_output("wr_ready", 32'(wr_ready), 32'(v.exp_ready));
        re.due = cyc + 1;
        re.data = 8'h00;
        if (v.dreq) begin
            re.we = 1'b0; re.addr = v.daddr;
            de.due = cyc + RD_LAT + 2;
            de.data = ref_mem[v.daddr[11:0]];
            disp_q.push_back(de);
        end else if (v.exp_ready == 2'b01) begin
            re.we = 1'b1; re.addr = v.a0; re.data = v.d0;
            ref_mem[v.a0[11:0]] = v.d0;
        end else if (v.exp_ready == 2'b10) begin
            re.we = 1'b1; re.addr = v.a1; re.data = v.d1;
            ref_mem[v.a1[11:0]] = v.d1;
        end else begin
            re.we = 1'b0; re.addr = last_addr;
        end
        last_addr = re.addr;
        ram_q.push_back(re);
    endtask

    ram_exp_t  mon_r;
    disp_exp_t mon_d;
    logic      mon_v;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_q.size() > 0 && ram_q[0].due == cyc) begin
                mon_r = ram_q.pop_front();
                check_output("ram_we", 32'(ram_we), 32'(mon_r.we));
                check_output("ram_addr", 32'(ram_addr), 32'(mon_r.addr));
                if (mon_r.we) check_output("ram_wdata", 32'(ram_wdata), 32'(mon_r.data));
            end
            mon_v = (disp_q.size() > 0) && (disp_q[0].due == cyc);
            check_output("disp_valid", 32'(disp_valid), 32'(mon_v));
            if (mon_v) begin
                mon_d = disp_q.pop_front();
                check_output("disp_data", 32'(disp_data), 32'(mon_d.data));
            end
        end
    end

    initial begin
        n_vec = 0;
        n_fail = 0;
        last_addr = '0;
        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        ref_mem[5] = 8'hA5;

        rst_n     = 1'b0;
        stats_clr = 1'b0;
        disp_req  = 1'b1;
        disp_addr = 19'd7;
        wr_valid  = 2'b11;
        wr_addr   = {19'd1, 19'd2};
        wr_data   = {8'h11, 8'h22};
        repeat (3) @(posedge clk);
        #3;
        check_output("rst_ram_we", 32'(ram_we), 32'd0);
        check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_output("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check_output("rst_disp_valid", 32'(disp_valid), 32'd0);
        check_output("rst_disp_data", 32'(disp_data), 32'd0);
        check_output("rst_wr_ready", 32'(wr_ready), 32'd0);
        check_output("rst_stall_cnt", stall_cnt, 32'd0);
        disp_req = 1'b0;
        wr_valid = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;

        vecs.push_back(fetch(19'd5));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(1'b1, 19'(10 + k), 2'b01, 19'h123, 8'h77, 19'd0, 8'd0, 2'b00));
        vecs.push_back(mk(1'b0, 19'd0, 2'b01, 19'h123, 8'h77, 19'd0, 8'd0, 2'b01));
        vecs.push_back(mk(1'b0, 19'd0, 2'b10, 19'd0, 8'd0, 19'h150, 8'h99, 2'b10));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1'b0, 19'd0, 2'b11, 19'(32'h200 + k), 8'(8'h40 + k),
                              19'(32'h300 + k), 8'(8'h80 + k), (k % 2 == 0) ? 2'b01 : 2'b10));
        vecs.push_back(mk(1'b0, 19'd0, 2'b10, 19'd0, 8'd0, 19'd100, 8'h3C, 2'b10));
        vecs.push_back(fetch(19'd100));
        vecs.push_back(fetch(19'h123));
        vecs.push_back(mk(1'b1, 19'h200, 2'b10, 19'd0, 8'd0, 19'h333, 8'hEE, 2'b00));
        vecs.push_back(idle());
        vecs.push_back(mk(1'b0, 19'd0, 2'b10, 19'd0, 8'd0, 19'h400, 8'h55, 2'b10));
        vecs.push_back(mk(1'b0, 19'd0, 2'b11, 19'h401, 8'h66, 19'h402, 8'h67, 2'b01));
        vecs.push_back(mk(1'b0, 19'd0, 2'b01, 19'h403, 8'h68, 19'd0, 8'd0, 2'b01));
        vecs.push_back(fetch(19'h400));
        vecs.push_back(fetch(19'h303));
        vecs.push_back(fetch(19'h403));
        for (int k = 0; k < 6; k++) vecs.push_back(idle());

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // Mid-stream reset: the three fetches in flight must never surface.
        apply_stimulus(fetch(19'h10));
        apply_stimulus(fetch(19'h11));
        apply_stimulus(fetch(19'h12));
        @(posedge clk);
        #1;
        disp_req = 1'b0;
        wr_valid = 2'b00;
        rst_n = 1'b0;
        ram_q.delete();
        disp_q.delete();
        last_addr = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) apply_stimulus(idle());
        apply_stimulus(fetch(19'd5));
        for (int k = 0; k < 6; k++) apply_stimulus(idle());

`ifdef VGA_FB_ARB_STATS_EN
        for (int k = 0; k < 70000; k++)
            apply_stimulus(mk(1'b1, 19'd5, 2'b10, 19'd0, 8'd0, 19'h500, 8'h01, 2'b00));
        apply_stimulus(idle());
        check_output("stall_cnt1_sat", 32'(stall_cnt[31:16]), 32'h0000FFFF);
        stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        apply_stimulus(idle());
        check_output("stall_cnt_clr", stall_cnt, 32'd0);
        for (int k = 0; k < 6; k++) apply_stimulus(idle());
`else
        check_output("stall_cnt_tied", stall_cnt, 32'd0);
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        check_output("disp_q_drained", 32'(disp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
